// File: rtl/alu_seq.sv
// alu_seq - sequential N-bit ALU used as the execute stage of the multicycle
// datapath. Every operation produces a registered result and flags (v, c, n, z)
// behind a valid/ready handshake.
//
// Operations (control): 000 add, 001 sub, 010 and, 011 or, 100 xor,
// 101 signed set-less-than, 110 unsigned multiply (shift-add, N steps),
// 111 reserved (yields result 0 with z=1).
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   a/b/control valid this cycle
//   in_ready   block can accept an operation (IDLE only)
//   a, b       N-bit operands
//   control    3-bit operation select
//   out_valid  result and flags valid (DONE)
//   out_ready  consumer accepts the result
//   result     registered N-bit result
//   v, c, n, z registered overflow/carry/negative/zero flags
//
// Optional build macro ALU_STICKY_OVF_EN adds:
//   sticky_clr input, clears v_sticky (a same-cycle overflow write wins)
//   v_sticky   output, set by any result write with v=1

module alu_seq #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   control,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         v,
    output logic         c,
    output logic         n,
    output logic         z
`ifdef ALU_STICKY_OVF_EN
    ,
    input  logic         sticky_clr,
    output logic         v_sticky
`endif
);

    localparam int          CW     = $clog2(N) + 1;
    localparam logic [2:0]  OP_MUL = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic w_accept;
    logic w_mul_last;

    logic [N-1:0]   r_result;
    logic           r_v;
    logic           r_c;
    logic           r_n;
    logic           r_z;
    logic [N-1:0]   r_mcand;
    logic [2*N-1:0] r_prod;
    logic [CW-1:0]  r_cnt;

    logic [N+1:0]   w_alu;
    logic [N:0]     w_psum;
    logic [2*N-1:0] w_prod_nx;

    // Single-cycle operations. Returns {v, c, result}.
    function automatic logic [N+1:0] alu_single(input logic [N-1:0] fa,
                                                input logic [N-1:0] fb,
                                                input logic [2:0]   op);
        logic [N:0]   sum;
        logic [N:0]   diff;
        logic [N-1:0] res;
        logic         fv;
        logic         fc;
        logic         lt;
        sum  = {1'b0, fa} + {1'b0, fb};
        diff = {1'b0, fa} + {1'b0, ~fb} + (N+1)'(1);
        res  = '0;
        fv   = 1'b0;
        fc   = 1'b0;
        // Differing signs decide directly; equal signs cannot overflow the
        // subtraction, so the difference sign is then exact.
        lt   = (fa[N-1] != fb[N-1]) ? fa[N-1] : diff[N-1];
        case (op)
            3'b000: begin
                res = sum[N-1:0];
                fc  = sum[N];
                fv  = (fa[N-1] == fb[N-1]) && (sum[N-1] != fa[N-1]);
            end
            3'b001: begin
                res = diff[N-1:0];
                fc  = diff[N];
                fv  = (fa[N-1] != fb[N-1]) && (diff[N-1] != fa[N-1]);
            end
            3'b010:  res = fa & fb;
            3'b011:  res = fa | fb;
            3'b100:  res = fa ^ fb;
            3'b101:  res = {{(N-1){1'b0}}, lt};
            default: res = '0;
        endcase
        return {fv, fc, res};
    endfunction

    assign w_alu = alu_single(a, b, control);

    // Shift-add step: the low half of r_prod starts as the multiplier and is
    // shifted out LSB-first while the partial sum grows into the high half.
    assign w_psum    = {1'b0, r_prod[2*N-1:N]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
    assign w_prod_nx = {w_psum, r_prod[N-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        w_accept   = 1'b0;
        w_mul_last = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = (control == OP_MUL) ? S_MUL : S_DONE;
                end
            end
            S_MUL: begin
                if (r_cnt == CW'(N - 1)) begin
                    w_mul_last = 1'b1;
                    w_next     = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result <= '0;
            r_v      <= 1'b0;
            r_c      <= 1'b0;
            r_n      <= 1'b0;
            r_z      <= 1'b0;
            r_mcand  <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_accept) begin
                if (control == OP_MUL) begin
                    r_mcand <= a;
                    r_prod  <= {{N{1'b0}}, b};
                    r_cnt   <= '0;
                end else begin
                    r_v      <= w_alu[N+1];
                    r_c      <= w_alu[N];
                    r_result <= w_alu[N-1:0];
                    r_n      <= w_alu[N-1];
                    r_z      <= (w_alu[N-1:0] == '0);
                end
            end
            if (r_state == S_MUL) begin
                r_prod <= w_prod_nx;
                r_cnt  <= r_cnt + CW'(1);
                if (w_mul_last) begin
                    r_result <= w_prod_nx[N-1:0];
                    r_c      <= |w_prod_nx[2*N-1:N];
                    r_v      <= 1'b0;
                    r_n      <= w_prod_nx[N-1];
                    r_z      <= (w_prod_nx[N-1:0] == '0);
                end
            end
        end
    end

    assign result = r_result;
    assign v      = r_v;
    assign c      = r_c;
    assign n      = r_n;
    assign z      = r_z;

`ifdef ALU_STICKY_OVF_EN
    logic r_v_sticky;
    logic w_ovf_wr;

    // Multiply writes always carry v=0, so only single-cycle writes can set it.
    assign w_ovf_wr = w_accept && (control != OP_MUL) && w_alu[N+1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v_sticky <= 1'b0;
        end else if (w_ovf_wr) begin
            r_v_sticky <= 1'b1;
        end else if (sticky_clr) begin
            r_v_sticky <= 1'b0;
        end
    end

    assign v_sticky = r_v_sticky;
`endif

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    localparam int N = 32;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   control;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         v;
    logic         c;
    logic         n;
    logic         z;
`ifdef ALU_STICKY_OVF_EN
    logic         sticky_clr;
    logic         v_sticky;
`endif

    alu_seq #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .control   (control),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .v         (v),
        .c         (c),
        .n         (n),
        .z         (z)
`ifdef ALU_STICKY_OVF_EN
        ,
        .sticky_clr(sticky_clr),
        .v_sticky  (v_sticky)
`endif
    );

    typedef struct packed {
        logic [N-1:0] r;
        logic         v;
        logic         c;
        logic         n;
        logic         z;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: every completed output handshake pops one expected response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 128'({result, v, c, n, z}), 128'h0);
                    n_bad += (128'({result, v, c, n, z}) == 128'h0) ? 1 : 0;
                end else begin
                    e = q.pop_front();
                    chk("result_flags", 128'({result, v, c, n, z}), 128'(e));
                end
            end
        end
    end

    // Issue one op with out_ready=1 and measure cycles from accept edge to out_valid.
    task automatic do_op(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic [2:0] tc,
                         input logic [N-1:0] er, input logic ev, input logic ec,
                         input logic en, input logic ez, input int exp_lat);
        int   lat;
        logic rdy_seen;
        chk("in_ready_before_op", 128'(in_ready), 128'(1));
        q.push_back('{r: er, v: ev, c: ec, n: en, z: ez});
        a        = ta;
        b        = tb;
        control  = tc;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = ~ta;
        b        = ~tb;
        control  = 3'b000;
        lat      = 1;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) rdy_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 128'(lat), 128'(exp_lat));
        chk("in_ready_busy", 128'({rdy_seen, in_ready}), 128'(0));
        @(posedge clk); #1;
        chk("back_to_idle", 128'({out_valid, in_ready}), 128'(2'b01));
    endtask

    initial begin
        int wait_cnt;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        control   = 3'b000;
`ifdef ALU_STICKY_OVF_EN
        sticky_clr = 1'b0;
`endif
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset_state", 128'({in_ready, out_valid, result, v, c, n, z}),
            128'({1'b1, 1'b0, 32'h0, 4'b0000}));
        reset = 1'b0;
        @(posedge clk); #1;

        // add / sub / logic / slt / reserved
        do_op(32'h7FFFFFFF, 32'h00000001, 3'b000, 32'h80000000, 1, 0, 1, 0, 1);
        do_op(32'hFFFFFFFF, 32'h00000001, 3'b000, 32'h00000000, 0, 1, 0, 1, 1);
        do_op(32'h00000005, 32'h00000007, 3'b001, 32'hFFFFFFFE, 0, 0, 1, 0, 1);
        do_op(32'h00000007, 32'h00000007, 3'b001, 32'h00000000, 0, 1, 0, 1, 1);
        do_op(32'h80000000, 32'h00000001, 3'b001, 32'h7FFFFFFF, 1, 1, 0, 0, 1);
        do_op(32'hFFFFFFFF, 32'h00000001, 3'b101, 32'h00000001, 0, 0, 0, 0, 1);
        do_op(32'h80000000, 32'h7FFFFFFF, 3'b101, 32'h00000001, 0, 0, 0, 0, 1);
        do_op(32'h00000001, 32'hFFFFFFFF, 3'b101, 32'h00000000, 0, 0, 0, 1, 1);
        do_op(32'hF0F0F0F0, 32'hFF00FF00, 3'b010, 32'hF000F000, 0, 0, 1, 0, 1);
        do_op(32'h0F0F0000, 32'h000000F0, 3'b011, 32'h0F0F00F0, 0, 0, 0, 0, 1);
        do_op(32'hAAAAAAAA, 32'h55555555, 3'b100, 32'hFFFFFFFF, 0, 0, 1, 0, 1);
        do_op(32'h00000005, 32'h00000006, 3'b111, 32'h00000000, 0, 0, 0, 1, 1);

        // multiply
        do_op(32'h00000003, 32'h00000005, 3'b110, 32'h0000000F, 0, 0, 0, 0, N + 1);
        do_op(32'h00010000, 32'h00010000, 3'b110, 32'h00000000, 0, 1, 0, 1, N + 1);
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b110, 32'h00000001, 0, 1, 0, 0, N + 1);

        // backpressure: held in DONE while inputs churn
        out_ready = 1'b0;
        q.push_back('{r: 32'h5, v: 1'b0, c: 1'b0, n: 1'b0, z: 1'b0});
        a = 32'h2; b = 32'h3; control = 3'b000; in_valid = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            a        = 32'h7FFFFFFF - i;
            b        = 32'h1 + i;
            control  = 3'(i);
            in_valid = i[0];
            @(posedge clk); #1;
            chk("bp_hold", 128'({out_valid, in_ready, result, v, c, n, z}),
                128'({1'b1, 1'b0, 32'h5, 4'b0000}));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", 128'({out_valid, in_ready, result}), 128'({1'b0, 1'b1, 32'h5}));

        // reset in the middle of a multiply: no output for the discarded op
        a = 32'h7; b = 32'h9; control = 3'b110; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("mul_busy", 128'({out_valid, in_ready}), 128'(0));
        reset = 1'b1;
        #1;
        chk("reset_mid_mul", 128'({out_valid, in_ready, result, v, c, n, z}),
            128'({1'b0, 1'b1, 32'h0, 4'b0000}));
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        do_op(32'h1, 32'h1, 3'b000, 32'h2, 0, 0, 0, 0, 1);

`ifdef ALU_STICKY_OVF_EN
        do_op(32'h7FFFFFFF, 32'h00000001, 3'b000, 32'h80000000, 1, 0, 1, 0, 1);
        chk("sticky_set", 128'(v_sticky), 128'(1));
        do_op(32'hFFFF0000, 32'h0F0F0F0F, 3'b010, 32'h0F0F0000, 0, 0, 0, 0, 1);
        chk("sticky_hold", 128'({v, v_sticky}), 128'(2'b01));
        sticky_clr = 1'b1;
        @(posedge clk); #1;
        sticky_clr = 1'b0;
        chk("sticky_clr", 128'(v_sticky), 128'(0));
`endif

        wait_cnt = 0;
        while (q.size() != 0 && wait_cnt < 100) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        chk("queue_drained", 128'(q.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised N-bit sequential ALU with registered result and flags (v, c, n, z) and valid/ready handshakes. Extends the combinational add/sub/and/or ALU with xor, signed set-less-than, and an iterative shift-add multiplier. Single-cycle ops complete in 1 cycle; multiply takes N cycles. Intended as the execute stage of the multicycle processor datapath.

Parameters:
N, 32, operand/result width in bits; legal range 4..64.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  operands and control are valid this cycle.
in_ready  output  1  block can accept an operation.
a  input  N  operand A.
b  input  N  operand B.
control  input  3  operation select: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 mul, 111 reserved.
out_valid  output  1  result and flags are valid.
out_ready  input  1  consumer accepts the result.
result  output  N  registered result.
v, c, n, z  output  1 each  registered flags: overflow, carry, negative, zero.

Behaviour:
- Reset (async, any state): state=IDLE; in_ready=1; out_valid=0; result=0; v=c=n=z=0; multiplier counter and product cleared. An operation in flight is discarded; no output is produced for it.
- FSM states: IDLE, MUL, DONE.
- IDLE: in_ready=1. Accept occurs on in_valid&in_ready. a, b and control are captured at the accept edge; later input changes have no effect.
  - Non-mul op: result/flags registered at the accept edge; next state DONE. out_valid rises the cycle after accept (latency 1).
  - mul: load multiplicand and multiplier, counter=0; next state MUL.
- MUL: in_ready=0. One shift-add step per cycle for N cycles (counter 0..N-1). After step N-1, write result/flags; next state DONE. out_valid is high N+1 cycles after the accept edge.
- DONE: out_valid=1, in_ready=0. result and flags stay stable while out_ready=0. On out_ready=1, go to IDLE; out_valid falls next cycle. No accept in DONE; maximum throughput is 1 op per 2 cycles.
- Arithmetic:
  - add: {c, result} = a + b (N+1 bits). v = (a[N-1]==b[N-1]) & (result[N-1]!=a[N-1]).
  - sub: result = a + ~b + 1. c = carry out, so c=1 means no borrow (a>=b unsigned). v = (a[N-1]!=b[N-1]) & (result[N-1]!=a[N-1]).
  - and/or/xor: bitwise. v=c=0.
  - slt: result = {N-1 zeros, signed(a)<signed(b)}. Must be correct on overflow (compare signs, then the sub result). v=c=0.
  - mul: 2N-bit unsigned product P. result = P[N-1:0]. c = |P[2N-1:N]. v=0.
  - All ops: n = result[N-1]; z = (result==0).
- control=111: treated as add with result forced to 0 and flags v=c=n=0, z=1; still produces one output (latency 1).
- Flags update only when a new result is written; they hold between operations.

Optional Feature:
ALU_STICKY_OVF_EN:
- Defined: adds input sticky_clr (1 bit) and output v_sticky (1 bit). v_sticky is set at any result write with v=1, and cleared by reset or by sticky_clr. If sticky_clr and a v=1 write occur in the same cycle, the set wins.
- Undefined: neither port exists; behaviour is otherwise identical.

Test Plan:
- Add overflow, N=32: a=0x7FFFFFFF, b=0x00000001, control=000 -> one cycle after accept: result=0x80000000, v=1, c=0, n=1, z=0. Then a=0xFFFFFFFF, b=1 -> result=0, c=1, z=1, v=0.
- Sub/slt: 5-7 -> result=0xFFFFFFFE, c=0, n=1, v=0. 7-7 -> result=0, c=1, z=1. slt a=0xFFFFFFFF, b=1 -> result=1. slt a=0x80000000, b=0x7FFFFFFF -> result=1.
- Multiply: 3*5 -> result=15, c=0, out_valid exactly 33 cycles after accept. 0x00010000*0x00010000 -> result=0, c=1, z=1. in_ready=0 throughout MUL.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling a, b and in_valid -> result and flags unchanged, in_ready=0, no new accept. Then out_ready=1 -> IDLE next cycle.
- Reset mid-multiply: assert reset 10 cycles into mul -> out_valid=0, result=0, all flags 0 immediately. After release, in_ready=1, and an add 1+1 returns 2 with latency 1.
- With ALU_STICKY_OVF_EN: overflowing add, then an and op -> v=0, v_sticky=1. Pulse sticky_clr -> v_sticky=0.
